// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage controller: FSM state encoding and
// the default per-bank address width.
package fft_pkg;

  localparam int unsigned DefAddrWidth = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMP,
    S_DRAIN,
    S_UNLOAD
  } fft_ctrl_state_e;

endpackage

// File: rtl/fft_wb_delay.sv
// Write-back delay line: carries a valid bit and bank address from butterfly
// read issue to write-back, exactly Depth cycles later.
module fft_wb_delay #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned AddrWidth = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  input  logic [AddrWidth-1:0] in_addr_i,
  output logic                 out_valid_o,
  output logic [AddrWidth-1:0] out_addr_o,
  output logic                 empty_o
);

  logic [Depth-1:0]                valid_q, valid_d;
  logic [Depth-1:0][AddrWidth-1:0] addr_q, addr_d;

  always_comb begin
    valid_d    = valid_q;
    addr_d     = addr_q;
    valid_d[0] = in_valid_i;
    addr_d[0]  = in_addr_i;
    for (int i = 1; i < Depth; i++) begin
      valid_d[i] = valid_q[i-1];
      addr_d[i]  = addr_q[i-1];
    end
  end

  // NOTE: the address stages are reset along with the valids, so the whole
  // pipeline (and out_addr_o) reads 0 under reset, not just the valid bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign out_valid_o = valid_q[Depth-1];
  assign out_addr_o  = addr_q[Depth-1];
  assign empty_o     = ~|valid_q;

endmodule

// File: rtl/fft_stage_ctrl.sv
// In-place radix-4 FFT stage controller: load, NumStages compute passes with
// delayed write-back, then unload. Define FFT_CTRL_TWIDDLE_EN to generate tw_idx_o.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned AddrWidth   = DefAddrWidth,
  parameter int unsigned NumStages   = 3,
  parameter int unsigned BflyLatency = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               start_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic                               bfly_ready_i,
  input  logic                               out_ready_i,
  output logic [3:0]                         ren_o,
  output logic [3:0]                         wen_o,
  output logic [3:0][AddrWidth-1:0]          raddr_o,
  output logic [3:0][AddrWidth-1:0]          waddr_o,
  output logic [$clog2(NumStages+1)-1:0]     stage_o,
  output logic [AddrWidth-1:0]               tw_idx_o,
  output logic                               bfly_valid_o,
  output logic                               out_valid_o,
  output logic                               busy_o,
  output logic                               done_o
);

  localparam int unsigned CntW   = AddrWidth + 2;
  localparam int unsigned StageW = $clog2(NumStages + 1);
  localparam logic [CntW-1:0]   CompLast  = CntW'((1 << AddrWidth) - 1);
  localparam logic [CntW-1:0]   LoadLast  = CntW'((4 << AddrWidth) - 1);
  localparam logic [StageW-1:0] StageLast = StageW'(NumStages - 1);

  fft_ctrl_state_e       state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [StageW-1:0]     stage_q, stage_d;
  logic                  out_valid_q, out_valid_d;
  logic                  done_q, done_d;
  logic                  issue;
  logic                  wb_valid, wb_empty;
  logic [AddrWidth-1:0]  wb_addr;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stage_d      = stage_q;
    out_valid_d  = 1'b0;
    done_d       = 1'b0;
    issue        = 1'b0;
    in_ready_o   = 1'b0;
    ren_o        = '0;
    wen_o        = '0;
    raddr_o      = '0;
    waddr_o      = '0;
    bfly_valid_o = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          stage_d = '0;
        end
      end
      S_LOAD: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          wen_o[cnt_q[1:0]] = 1'b1;
          waddr_o           = {4{cnt_q[AddrWidth+1:2]}};
          if (cnt_q == LoadLast) begin
            state_d = S_COMP;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      S_COMP: begin
        if (bfly_ready_i) begin
          issue        = 1'b1;
          bfly_valid_o = 1'b1;
          ren_o        = '1;
          raddr_o      = {4{cnt_q[AddrWidth-1:0]}};
          cnt_d        = cnt_q + CntW'(1);
          if (cnt_q == CompLast) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wb_empty) begin
          cnt_d = '0;
          if (stage_q < StageLast) begin
            stage_d = stage_q + StageW'(1);
            state_d = S_COMP;
          end else begin
            state_d = S_UNLOAD;
          end
        end
      end
      S_UNLOAD: begin
        if (out_ready_i) begin
          ren_o[cnt_q[1:0]]   = 1'b1;
          raddr_o[cnt_q[1:0]] = cnt_q[AddrWidth+1:2];
          out_valid_d         = 1'b1;
          if (cnt_q == LoadLast) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Write-back is driven purely by the delay line, so a stalled read side
    // never delays results already in flight.
    if (wb_valid) begin
      wen_o   = '1;
      waddr_o = {4{wb_addr}};
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its _d value from before this edge, regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stage_q     <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stage_q     <= stage_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  fft_wb_delay #(
    .Depth     (BflyLatency),
    .AddrWidth (AddrWidth)
  ) u_wb_delay (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (issue),
    .in_addr_i   (cnt_q[AddrWidth-1:0]),
    .out_valid_o (wb_valid),
    .out_addr_o  (wb_addr),
    .empty_o     (wb_empty)
  );

`ifdef FFT_CTRL_TWIDDLE_EN
  logic [AddrWidth-1:0] r_idx;
  assign r_idx    = cnt_q[AddrWidth-1:0];
  assign tw_idx_o = (state_q == S_COMP) ? (r_idx << {stage_q, 1'b0}) : '0;
`else
  assign tw_idx_o = '0;
`endif

  assign stage_o     = stage_q;
  assign out_valid_o = out_valid_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl (AddrWidth=7, NumStages=3, BflyLatency=4):
// stimulus queues expected transactions, a negedge monitor pops and compares.
module tb_fft_stage_ctrl;
  import fft_pkg::*;

  localparam int AW = 7;
  localparam int NS = 3;
  localparam int BL = 4;
  localparam int D  = 1 << AW;
  localparam int N  = 4 * D;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 start_i = 1'b0;
  logic                 in_valid_i = 1'b0;
  logic                 bfly_ready_i = 1'b0;
  logic                 out_ready_i = 1'b0;
  logic                 in_ready_o;
  logic [3:0]           ren_o, wen_o;
  logic [3:0][AW-1:0]   raddr_o, waddr_o;
  logic [1:0]           stage_o;
  logic [AW-1:0]        tw_idx_o;
  logic                 bfly_valid_o, out_valid_o, busy_o, done_o;

  fft_stage_ctrl #(
    .AddrWidth   (AW),
    .NumStages   (NS),
    .BflyLatency (BL)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .bfly_ready_i (bfly_ready_i),
    .out_ready_i  (out_ready_i),
    .ren_o        (ren_o),
    .wen_o        (wen_o),
    .raddr_o      (raddr_o),
    .waddr_o      (waddr_o),
    .stage_o      (stage_o),
    .tw_idx_o     (tw_idx_o),
    .bfly_valid_o (bfly_valid_o),
    .out_valid_o  (out_valid_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {int r; int stage;} rd_t;
  typedef struct {int r; int cyc;}   wb_t;

  int  exp_ld[$];
  rd_t exp_rd[$];
  wb_t pend[$];
  int  exp_ul[$];
  int  ul_cyc[$];
  int  ul_issued   = 0;
  int  last_ul_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_tw(input int r, input int s);
`ifdef FFT_CTRL_TWIDDLE_EN
    return (r << (2 * s)) & (D - 1);
`else
    return 0;
`endif
  endfunction

  // Monitor: pops expectations whenever the DUT presents a transaction.
  int  mon_n;
  rd_t mon_e;
  wb_t mon_p;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      ul_issued = 0;
    end else begin
      if (wen_o == 4'hF) begin
        if (pend.size() == 0) check("wb_unexpected", 1, 0);
        else begin
          mon_p = pend.pop_front();
          check("wb_addr", waddr_o, {4{AW'(mon_p.r)}});
          check("wb_latency", cyc - mon_p.cyc, BL);
        end
      end else if (wen_o != 4'h0) begin
        if (exp_ld.size() == 0) check("ld_unexpected", 1, 0);
        else begin
          mon_n = exp_ld.pop_front();
          check("ld_wen", wen_o, 4'b0001 << (mon_n % 4));
          check("ld_waddr", waddr_o[mon_n % 4], mon_n / 4);
          check("ld_ready", in_ready_o, 1);
        end
      end

      if (out_valid_o) begin
        if (ul_cyc.size() == 0) check("ov_unexpected", 1, 0);
        else check("ov_latency", cyc - ul_cyc.pop_front(), 1);
      end

      if (done_o) begin
        check("done_count", ul_issued, N);
        check("done_timing", cyc - last_ul_cyc, 1);
        check("done_idle", busy_o, 0);
        ul_issued = 0;
      end

      for (int b = 0; b < 4; b++)
        if (ren_o[b] && wen_o[b]) check("rw_conflict", raddr_o[b] == waddr_o[b], 0);

      if (bfly_valid_o) begin
        check("rd_ready", bfly_ready_i, 1);
        if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          mon_e = exp_rd.pop_front();
          check("rd_ren", ren_o, 4'hF);
          check("rd_addr", raddr_o, {4{AW'(mon_e.r)}});
          check("rd_stage", stage_o, mon_e.stage);
          check("rd_tw", tw_idx_o, exp_tw(mon_e.r, mon_e.stage));
          if (mon_e.r == 0 && mon_e.stage > 0) check("stage_after_wb", pend.size(), 0);
          pend.push_back('{mon_e.r, cyc});
        end
      end else if (ren_o != 4'h0) begin
        check("ul_ready", out_ready_i, 1);
        if (exp_ul.size() == 0) check("ul_unexpected", 1, 0);
        else begin
          mon_n = exp_ul.pop_front();
          check("ul_ren", ren_o, 4'b0001 << (mon_n % 4));
          check("ul_addr", raddr_o[mon_n % 4], mon_n / 4);
        end
        ul_cyc.push_back(cyc);
        ul_issued++;
        last_ul_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, {raddr_o, waddr_o}, '0);
    check({tag, "_ctrl"}, {in_ready_o, ren_o, wen_o, stage_o, tw_idx_o,
                           bfly_valid_o, out_valid_o, busy_o, done_o}, '0);
  endtask

  task automatic run_transform(input bit stall, input bit abort);
    bit hit;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    #1;
    check("load_ready", {busy_o, in_ready_o}, 2'b11);

    for (int s = 0; s < NS; s++)
      for (int r = 0; r < D; r++) exp_rd.push_back('{r, s});
    for (int n = 0; n < N; n++) exp_ul.push_back(n);

    bfly_ready_i = 1'b1;
    for (int n = 0; n < N; n++) begin
      exp_ld.push_back(n);
      in_valid_i = 1'b1;
      step();
    end
    in_valid_i = 1'b0;
    #1;
    check("comp_entry", {in_ready_o, bfly_valid_o, raddr_o[0]}, {1'b0, 1'b1, 7'd0});

    if (stall) begin
      hit = 1'b0;
      for (int i = 0; i < 400 && !hit; i++) begin
        if (bfly_valid_o && raddr_o[0] == AW'(49) && stage_o == 2'd0) hit = 1'b1;
        else step();
      end
      check("wait_r49", hit, 1);
      step();
      bfly_ready_i = 1'b0;
      start_i      = 1'b1;
      for (int i = 0; i < 10; i++) begin
        #1;
        check("stall_no_read", {bfly_valid_o, ren_o}, '0);
        step();
        start_i = 1'b0;
      end
      bfly_ready_i = 1'b1;
    end

    if (abort) begin
      hit = 1'b0;
      for (int i = 0; i < 1000 && !hit; i++) begin
        if (bfly_valid_o && stage_o == 2'd1 && raddr_o[0] == AW'(20)) hit = 1'b1;
        else step();
      end
      check("wait_s1_r20", hit, 1);
      #1 rst_ni = 1'b0;
      #1;
      check_all_zero("rst_now");
      exp_ld.delete();
      exp_rd.delete();
      pend.delete();
      exp_ul.delete();
      ul_cyc.delete();
      bfly_ready_i = 1'b0;
      step();
      step();
      check_all_zero("rst_hold");
      rst_ni = 1'b1;
      step();
      check("idle_after_rst", {busy_o, in_ready_o}, '0);
      return;
    end

    hit = 1'b0;
    for (int i = 0; i < 6000 && !hit; i++) begin
      out_ready_i = (i % 3 != 2);
      step();
      if (done_o) hit = 1'b1;
    end
    check("wait_done", hit, 1);
    out_ready_i  = 1'b0;
    bfly_ready_i = 1'b0;
    check("idle_at_done", {busy_o, in_ready_o}, '0);
    step();
    check("done_single", done_o, 0);
    check("rd_q_empty", exp_rd.size(), 0);
    check("ld_q_empty", exp_ld.size(), 0);
    check("wb_q_empty", pend.size(), 0);
    check("ul_q_empty", exp_ul.size(), 0);
    check("ov_q_empty", ul_cyc.size(), 0);
  endtask

  initial begin
    rst_ni = 1'b0;
    #12;
    check_all_zero("reset");
    rst_ni = 1'b1;
    step();
    check("idle_outputs", {busy_o, in_ready_o, done_o, ren_o, wen_o}, '0);

    run_transform(1'b1, 1'b0);
    run_transform(1'b0, 1'b1);
    run_transform(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
